frame_feature_extractor: RTL and testbench
==========================================

Name: frame_feature_extractor

Overview:
- Downstream of the camera capture stage. Consumes its pixel stream (pixel byte, pixel valid, frame_start/frame_done pulses) and reduces each frame to per-frame statistics: pixel count, bright-pixel count (≥ threshold), min, max, mean.
- Results go to the classifier via a valid/ready handshake.
- Mean is computed by a sequential divider after frame end.

Parameters:
- CNT_W, 16: width of pixel/bright counters; counters saturate at 2^CNT_W-1.
- SUM_W, CNT_W+8: width of the saturating luminance accumulator.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pixel_in  in  8  grayscale pixel from capture stage
- pixel_valid  in  1  pixel_in valid this cycle
- frame_start  in  1  single-cycle frame-begin pulse
- frame_done  in  1  single-cycle frame-end pulse
- threshold  in  8  bright-pixel threshold; sampled at frame_start
- feat_ready  in  1  consumer accepts result
- feat_valid  out  1  result valid, held until accepted
- pix_count  out  CNT_W  pixels in frame
- bright_count  out  CNT_W  pixels with value ≥ threshold
- pix_min  out  8  minimum pixel
- pix_max  out  8  maximum pixel
- pix_mean  out  8  floor(sum/pix_count)
- overflow  out  1  any counter or accumulator saturated this frame
- frame_dropped  out  1  sticky; a frame was skipped while busy; cleared on handshake
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset (async, rst_n low):
  - all outputs 0; state IDLE.
  - Accumulators 0; min register 8'hFF, max register 0.
- States: IDLE, ACCUM, DIVIDE, REPORT.
- IDLE:
  - frame_start → ACCUM. Clear counters and sum; min=FF, max=00; latch threshold.
  - pixel_valid and frame_done ignored.
- ACCUM: on each pixel_valid:
  - pix_count+1, sum+pixel_in.
  - bright_count+1 if pixel_in ≥ latched threshold.
  - Update min and max.
  - Any saturating counter/sum sets overflow (sticky for the frame).
- Same-cycle events in ACCUM:
  - pixel_valid with frame_done: pixel is counted, then state → DIVIDE.
  - frame_start again: restart. Accumulators cleared, then the same-cycle pixel is counted into the new frame; frame_dropped set.
  - pixel_valid with frame_start from IDLE: pixel counted into the new frame.
- DIVIDE:
  - 8-iteration restoring divider, one quotient bit per cycle, MSB first. Valid because quotient ≤ 255.
  - Edge sampling frame_done = E0. Iterations on E1..E8. On E9 → REPORT with feat_valid=1, i.e. 9 cycles after frame_done sampled.
  - pix_count = 0 → mean = 0; min and max outputs forced to 0.
- REPORT:
  - Outputs stable while feat_valid=1.
  - On feat_valid & feat_ready: feat_valid → 0, frame_dropped cleared, → IDLE. No same-cycle restart; a frame_start in that cycle is dropped.
- Frames during DIVIDE/REPORT:
  - frame_start is ignored and sets frame_dropped. Remaining pixels and frame_done of that frame are ignored.
  - frame_dropped sets and clears on the same edge: set wins.
- Outputs are registered. Result registers update only on the REPORT entry edge.
- Reset mid-operation: immediate return to reset values; no partial result emitted.

Optional Feature:
- Macro: FEAT_HIST_EN.
- Defined:
  - Adds outputs hist0..hist3, each CNT_W wide: 4-bin histogram indexed by pixel_in[7:6].
  - Saturating; contributes to overflow; cleared at frame_start; valid with feat_valid.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package:
  - state enum (IDLE/ACCUM/DIVIDE/REPORT, 2-bit)
  - MEAN_W=8
  - DIV_ITERS=8
  - FF/00 min/max init constants
- One sub-module, feat_seq_divider: start/done handshake, SUM_W dividend, CNT_W divisor, 8-bit quotient, fixed 8-cycle latency.

Test Plan:
- 4x4 frame, all pixels 100, threshold 50, feat_ready=1 → pix_count=16, bright=16, min=max=mean=100, overflow=0; feat_valid 9 cycles after frame_done.
- 16-pixel ramp 0..15, threshold 8 → pix_count=16, bright=8, min=0, max=15, mean=7 (120/16 floored).
- frame_start then frame_done with no pixels → pix_count=0, mean=0, min=0, max=0, feat_valid pulses once.
- feat_ready low 30 cycles; second frame_start during REPORT → outputs stay stable, frame_dropped=1. Raise ready → frame_dropped=0, IDLE, second frame not reported.
- CNT_W=4, 20 pixels of 255 → pix_count=15, overflow=1; rst_n pulse mid-ACCUM → all outputs 0, no feat_valid.
- FEAT_HIST_EN defined, pixels {0,64,128,192,255} → hist0..3 = 1,1,1,2.

Source files
------------

// File: rtl/frame_feature_extractor_pkg.sv
// ============================================================================
// Module : frame_feature_extractor_pkg
// Brief  : Shared types and constants for the frame feature extractor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_feature_extractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int         MEAN_W    = 8;
    localparam int         DIV_ITERS = 8;
    localparam logic [7:0] MIN_INIT  = 8'hFF;
    localparam logic [7:0] MAX_INIT  = 8'h00;

endpackage

`default_nettype wire

// File: rtl/feat_seq_divider.sv
// ============================================================================
// Module : feat_seq_divider
// Brief  : Restoring divider, one quotient bit per cycle MSB first, 8-cycle latency.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feat_seq_divider
    import frame_feature_extractor_pkg::*;
#(
    parameter int SUM_W = 24,
    parameter int CNT_W = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [SUM_W-1:0]  i_dividend,
    input  logic [CNT_W-1:0]  i_divisor,
    output logic              o_done,
    output logic [MEAN_W-1:0] o_quotient
);

    localparam int TW = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + MEAN_W + 1;
    localparam int KW = $clog2(DIV_ITERS);

    logic [TW-1:0]     r_rem, w_rem_in, w_shift, w_rem_nxt;
    logic [CNT_W-1:0]  r_dsr, w_dsr;
    logic [KW-1:0]     r_k, w_k;
    logic [MEAN_W-1:0] r_quo;
    logic              r_busy, r_done, r_sat, w_ge, w_sat;

    // The first iteration runs straight off the operands on the start edge.
    always_comb begin
        w_rem_in  = i_start ? TW'(i_dividend) : r_rem;
        w_dsr     = i_start ? i_divisor : r_dsr;
        w_k       = i_start ? KW'(DIV_ITERS - 1) : r_k;
        w_shift   = TW'(w_dsr) << w_k;
        w_ge      = (w_rem_in >= w_shift);
        w_rem_nxt = w_ge ? (w_rem_in - w_shift) : w_rem_in;
        w_sat     = (TW'(i_dividend) >= (TW'(i_divisor) << MEAN_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dsr  <= '0;
            r_k    <= '0;
            r_quo  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_rem  <= w_rem_nxt;
                r_dsr  <= i_divisor;
                r_k    <= KW'(DIV_ITERS - 2);
                r_quo  <= {w_ge, {(MEAN_W-1){1'b0}}};
                r_sat  <= w_sat;
            end else if (r_busy) begin
                r_rem      <= w_rem_nxt;
                r_quo[r_k] <= w_ge;
                if (r_k == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_k <= r_k - 1'b1;
                end
            end
        end
    end

    // A saturated sum can exceed 255 * count; clamp instead of wrapping.
    assign o_done     = r_done;
    assign o_quotient = r_sat ? {MEAN_W{1'b1}} : r_quo;

endmodule

`default_nettype wire

// File: rtl/frame_feature_extractor.sv
// ============================================================================
// Module : frame_feature_extractor
// Brief  : Per-frame pixel statistics with valid/ready result port.
//          Define FEAT_HIST_EN to add the 4-bin histogram outputs hist0..hist3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_feature_extractor
    import frame_feature_extractor_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = CNT_W + 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       pixel_in,
    input  logic             pixel_valid,
    input  logic             frame_start,
    input  logic             frame_done,
    input  logic [7:0]       threshold,
    input  logic             feat_ready,
    output logic             feat_valid,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] bright_count,
    output logic [7:0]       pix_min,
    output logic [7:0]       pix_max,
    output logic [7:0]       pix_mean,
    output logic             overflow,
    output logic             frame_dropped,
    output logic             busy
`ifdef FEAT_HIST_EN
    ,
    output logic [CNT_W-1:0] hist0,
    output logic [CNT_W-1:0] hist1,
    output logic [CNT_W-1:0] hist2,
    output logic [CNT_W-1:0] hist3
`endif
);

    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, r_bcnt, w_cnt_n, w_bcnt_n;
    logic [SUM_W-1:0]  r_sum, w_sum_n;
    logic [SUM_W:0]    w_sum_add;
    logic [7:0]        r_min, r_max, r_thr, w_min_n, w_max_n, w_thr_n;
    logic              r_ovf, w_ovf_n, r_div_start;
    logic              w_clear, w_count, w_hs, w_drop_set, w_div_done;
    logic [MEAN_W-1:0] w_quot;

    logic [CNT_W-1:0]  r_o_cnt, r_o_bcnt;
    logic [7:0]        r_o_min, r_o_max, r_o_mean;
    logic              r_o_ovf, r_o_valid, r_o_drop;

`ifdef FEAT_HIST_EN
    logic [CNT_W-1:0]  r_hacc [4];
    logic [CNT_W-1:0]  w_hacc_n [4];
    logic [CNT_W-1:0]  r_o_hist [4];
`endif

    assign w_clear    = frame_start && (r_state == ST_IDLE || r_state == ST_ACCUM);
    assign w_count    = pixel_valid && (r_state == ST_ACCUM || w_clear);
    assign w_hs       = r_o_valid && feat_ready;
    assign w_drop_set = frame_start && (r_state != ST_IDLE);

    // Clear-then-count lets a pixel on the frame_start cycle land in the new frame.
    always_comb begin
        w_thr_n   = w_clear ? threshold : r_thr;
        w_cnt_n   = w_clear ? '0 : r_cnt;
        w_bcnt_n  = w_clear ? '0 : r_bcnt;
        w_sum_n   = w_clear ? '0 : r_sum;
        w_min_n   = w_clear ? MIN_INIT : r_min;
        w_max_n   = w_clear ? MAX_INIT : r_max;
        w_ovf_n   = w_clear ? 1'b0 : r_ovf;
        w_sum_add = {1'b0, w_sum_n} + (SUM_W+1)'(pixel_in);
`ifdef FEAT_HIST_EN
        for (int b = 0; b < 4; b++) w_hacc_n[b] = w_clear ? '0 : r_hacc[b];
`endif
        if (w_count) begin
            if (&w_cnt_n) w_ovf_n = 1'b1;
            else          w_cnt_n = w_cnt_n + 1'b1;
            if (pixel_in >= w_thr_n) begin
                if (&w_bcnt_n) w_ovf_n  = 1'b1;
                else           w_bcnt_n = w_bcnt_n + 1'b1;
            end
            if (w_sum_add[SUM_W]) begin
                w_sum_n = '1;
                w_ovf_n = 1'b1;
            end else begin
                w_sum_n = w_sum_add[SUM_W-1:0];
            end
            if (pixel_in < w_min_n) w_min_n = pixel_in;
            if (pixel_in > w_max_n) w_max_n = pixel_in;
`ifdef FEAT_HIST_EN
            if (&w_hacc_n[pixel_in[7:6]]) w_ovf_n = 1'b1;
            else w_hacc_n[pixel_in[7:6]] = w_hacc_n[pixel_in[7:6]] + 1'b1;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:   if (frame_start) w_state_n = ST_ACCUM;
            ST_ACCUM:  if (!frame_start && frame_done) w_state_n = ST_DIVIDE;
            ST_DIVIDE: if (w_div_done) w_state_n = ST_REPORT;
            ST_REPORT: if (w_hs) w_state_n = ST_IDLE;
            default:   w_state_n = ST_IDLE;
        endcase
    end

    feat_seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (r_div_start),
        .i_dividend (r_sum),
        .i_divisor  (r_cnt),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_sum       <= '0;
            r_min       <= MIN_INIT;
            r_max       <= MAX_INIT;
            r_thr       <= '0;
            r_ovf       <= 1'b0;
            r_div_start <= 1'b0;
            r_o_cnt     <= '0;
            r_o_bcnt    <= '0;
            r_o_min     <= '0;
            r_o_max     <= '0;
            r_o_mean    <= '0;
            r_o_ovf     <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_drop    <= 1'b0;
`ifdef FEAT_HIST_EN
            for (int b = 0; b < 4; b++) begin
                r_hacc[b]   <= '0;
                r_o_hist[b] <= '0;
            end
`endif
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bcnt      <= w_bcnt_n;
            r_sum       <= w_sum_n;
            r_min       <= w_min_n;
            r_max       <= w_max_n;
            r_thr       <= w_thr_n;
            r_ovf       <= w_ovf_n;
            r_div_start <= (r_state == ST_ACCUM) && (w_state_n == ST_DIVIDE);
`ifdef FEAT_HIST_EN
            for (int b = 0; b < 4; b++) r_hacc[b] <= w_hacc_n[b];
`endif
            if (r_state == ST_DIVIDE && w_div_done) begin
                r_o_valid <= 1'b1;
                r_o_cnt   <= r_cnt;
                r_o_bcnt  <= r_bcnt;
                r_o_ovf   <= r_ovf;
                r_o_mean  <= (r_cnt == '0) ? 8'h00 : w_quot;
                r_o_min   <= (r_cnt == '0) ? 8'h00 : r_min;
                r_o_max   <= (r_cnt == '0) ? 8'h00 : r_max;
`ifdef FEAT_HIST_EN
                for (int b = 0; b < 4; b++) r_o_hist[b] <= r_hacc[b];
`endif
            end else if (w_hs) begin
                r_o_valid <= 1'b0;
            end
            if (w_drop_set)  r_o_drop <= 1'b1;
            else if (w_hs)   r_o_drop <= 1'b0;
        end
    end

    assign feat_valid    = r_o_valid;
    assign pix_count     = r_o_cnt;
    assign bright_count  = r_o_bcnt;
    assign pix_min       = r_o_min;
    assign pix_max       = r_o_max;
    assign pix_mean      = r_o_mean;
    assign overflow      = r_o_ovf;
    assign frame_dropped = r_o_drop;
    assign busy          = (r_state != ST_IDLE);
`ifdef FEAT_HIST_EN
    assign hist0 = r_o_hist[0];
    assign hist1 = r_o_hist[1];
    assign hist2 = r_o_hist[2];
    assign hist3 = r_o_hist[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_feature_extractor.sv
// ============================================================================
// Module : tb_frame_feature_extractor
// Brief  : Directed self-checking bench for frame_feature_extractor (FEAT_HIST_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_feature_extractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_done = 1'b0;
    logic [7:0]  threshold = '0;
    logic        feat_ready = 1'b1;

    logic        feat_valid, overflow, frame_dropped, busy;
    logic [15:0] pix_count, bright_count;
    logic [7:0]  pix_min, pix_max, pix_mean;
    logic        s_feat_valid, s_overflow, s_frame_dropped, s_busy;
    logic [3:0]  s_pix_count, s_bright_count;
    logic [7:0]  s_pix_min, s_pix_max, s_pix_mean;
`ifdef FEAT_HIST_EN
    logic [15:0] hist0, hist1, hist2, hist3;
    logic [3:0]  s_hist0, s_hist1, s_hist2, s_hist3;
`endif

    int          checks = 0;
    int          passes = 0;
    int          lat;
    logic [7:0]  q[$];

    always #5 clk = ~clk;

    frame_feature_extractor dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .frame_done(frame_done), .threshold(threshold),
        .feat_ready(feat_ready), .feat_valid(feat_valid), .pix_count(pix_count),
        .bright_count(bright_count), .pix_min(pix_min), .pix_max(pix_max),
        .pix_mean(pix_mean), .overflow(overflow), .frame_dropped(frame_dropped),
        .busy(busy)
`ifdef FEAT_HIST_EN
        , .hist0(hist0), .hist1(hist1), .hist2(hist2), .hist3(hist3)
`endif
    );

    frame_feature_extractor #(.CNT_W(4), .SUM_W(12)) dut_s (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .frame_done(frame_done), .threshold(threshold),
        .feat_ready(feat_ready), .feat_valid(s_feat_valid), .pix_count(s_pix_count),
        .bright_count(s_bright_count), .pix_min(s_pix_min), .pix_max(s_pix_max),
        .pix_mean(s_pix_mean), .overflow(s_overflow), .frame_dropped(s_frame_dropped),
        .busy(s_busy)
`ifdef FEAT_HIST_EN
        , .hist0(s_hist0), .hist1(s_hist1), .hist2(s_hist2), .hist3(s_hist3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends q as one frame; lat = cycles from the frame_done edge to feat_valid (-1 on timeout).
    task automatic run_frame(input logic [7:0] thr);
        frame_start = 1'b1; threshold = thr; pixel_valid = 1'b0;
        tick();
        frame_start = 1'b0;
        foreach (q[i]) begin
            pixel_in = q[i]; pixel_valid = 1'b1;
            tick();
        end
        pixel_valid = 1'b0; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (lat < 0) begin
                tick();
                if (feat_valid === 1'b1) lat = n;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (feat_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", feat_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (pix_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", pix_count); else passes++;
        checks++; if (pix_min !== 8'd0) $display("FAIL reset_min: got %0d want 0", pix_min); else passes++;
        checks++; if (frame_dropped !== 1'b0) $display("FAIL reset_drop: got %b want 0", frame_dropped); else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_uniform();
        feat_ready = 1'b1;
        q.delete();
        repeat (16) q.push_back(8'd100);
        run_frame(8'd50);
        checks++; if (lat !== 9) $display("FAIL uni_latency: got %0d want 9", lat); else passes++;
        checks++; if (pix_count !== 16'd16) $display("FAIL uni_count: got %0d want 16", pix_count); else passes++;
        checks++; if (bright_count !== 16'd16) $display("FAIL uni_bright: got %0d want 16", bright_count); else passes++;
        checks++; if (pix_min !== 8'd100 || pix_max !== 8'd100) $display("FAIL uni_minmax: got %0d/%0d want 100/100", pix_min, pix_max); else passes++;
        checks++; if (pix_mean !== 8'd100) $display("FAIL uni_mean: got %0d want 100", pix_mean); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL uni_ovf: got %b want 0", overflow); else passes++;
        tick();
        checks++; if (feat_valid !== 1'b0 || busy !== 1'b0) $display("FAIL uni_release: valid %b busy %b want 0 0", feat_valid, busy); else passes++;
    endtask

    task automatic test_ramp();
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        run_frame(8'd8);
        checks++; if (lat !== 9) $display("FAIL ramp_latency: got %0d want 9", lat); else passes++;
        checks++; if (pix_count !== 16'd16) $display("FAIL ramp_count: got %0d want 16", pix_count); else passes++;
        checks++; if (bright_count !== 16'd8) $display("FAIL ramp_bright: got %0d want 8", bright_count); else passes++;
        checks++; if (pix_min !== 8'd0 || pix_max !== 8'd15) $display("FAIL ramp_minmax: got %0d/%0d want 0/15", pix_min, pix_max); else passes++;
        checks++; if (pix_mean !== 8'd7) $display("FAIL ramp_mean: got %0d want 7", pix_mean); else passes++;
        tick();
    endtask

    task automatic test_empty();
        int extra;
        q.delete();
        run_frame(8'd0);
        checks++; if (lat !== 9) $display("FAIL empty_latency: got %0d want 9", lat); else passes++;
        checks++; if (pix_count !== 16'd0 || pix_mean !== 8'd0) $display("FAIL empty_cnt_mean: got %0d/%0d want 0/0", pix_count, pix_mean); else passes++;
        checks++; if (pix_min !== 8'd0 || pix_max !== 8'd0) $display("FAIL empty_minmax: got %0d/%0d want 0/0", pix_min, pix_max); else passes++;
        extra = 0;
        repeat (6) begin
            tick();
            if (feat_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0) $display("FAIL empty_pulse: extra valid cycles %0d want 0", extra); else passes++;
    endtask

    task automatic test_backpressure();
        int changed, seen;
        feat_ready = 1'b0;
        q = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_frame(8'd25);
        checks++; if (lat !== 9) $display("FAIL bp_latency: got %0d want 9", lat); else passes++;
        changed = 0;
        for (int c = 0; c < 30; c++) begin
            frame_start = (c == 10); threshold = 8'd0;
            tick();
            if (feat_valid !== 1'b1 || pix_count !== 16'd4 || bright_count !== 16'd2 ||
                pix_min !== 8'd10 || pix_max !== 8'd40 || pix_mean !== 8'd25) changed++;
        end
        frame_start = 1'b0;
        checks++; if (changed !== 0) $display("FAIL bp_stable: %0d cycles differed from 4/2/10/40/25", changed); else passes++;
        checks++; if (frame_dropped !== 1'b1) $display("FAIL bp_drop_set: got %b want 1", frame_dropped); else passes++;
        feat_ready = 1'b1;
        tick();
        checks++; if (feat_valid !== 1'b0 || frame_dropped !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_accept: valid %b drop %b busy %b want 0 0 0", feat_valid, frame_dropped, busy); else passes++;
        pixel_in = 8'd99; pixel_valid = 1'b1; tick(); tick();
        pixel_valid = 1'b0; frame_done = 1'b1; tick(); frame_done = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (feat_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL bp_orphan: %0d active cycles want 0", seen); else passes++;
    endtask

    task automatic test_same_cycle();
        feat_ready = 1'b0;
        frame_start = 1'b1; threshold = 8'd100; pixel_in = 8'd200; pixel_valid = 1'b1; tick();
        frame_start = 1'b0; pixel_in = 8'd50; tick();
        frame_start = 1'b1; threshold = 8'd130; pixel_in = 8'd120; tick();
        frame_start = 1'b0; threshold = 8'd0; pixel_in = 8'd140; frame_done = 1'b1; tick();
        frame_done = 1'b0; pixel_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) if (lat < 0) begin tick(); if (feat_valid === 1'b1) lat = n; end
        checks++; if (lat !== 9) $display("FAIL sc_latency: got %0d want 9", lat); else passes++;
        checks++; if (pix_count !== 16'd2 || bright_count !== 16'd1) $display("FAIL sc_counts: got %0d/%0d want 2/1", pix_count, bright_count); else passes++;
        checks++; if (pix_min !== 8'd120 || pix_max !== 8'd140 || pix_mean !== 8'd130)
            $display("FAIL sc_stats: got %0d/%0d/%0d want 120/140/130", pix_min, pix_max, pix_mean); else passes++;
        checks++; if (frame_dropped !== 1'b1) $display("FAIL sc_drop: got %b want 1", frame_dropped); else passes++;
        feat_ready = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (feat_valid !== 1'b0 || frame_dropped !== 1'b1 || busy !== 1'b0)
            $display("FAIL sc_set_wins: valid %b drop %b busy %b want 0 1 0", feat_valid, frame_dropped, busy); else passes++;
    endtask

    task automatic test_saturate();
        q.delete();
        repeat (20) q.push_back(8'd255);
        run_frame(8'd0);
        checks++; if (s_feat_valid !== 1'b1 || s_pix_count !== 4'd15 || s_bright_count !== 4'd15)
            $display("FAIL sat_counts: valid %b cnt %0d bright %0d want 1 15 15", s_feat_valid, s_pix_count, s_bright_count); else passes++;
        checks++; if (s_overflow !== 1'b1) $display("FAIL sat_ovf: got %b want 1", s_overflow); else passes++;
        checks++; if (s_pix_mean !== 8'd255 || s_pix_max !== 8'd255) $display("FAIL sat_mean_max: got %0d/%0d want 255/255", s_pix_mean, s_pix_max); else passes++;
        checks++; if (pix_count !== 16'd20 || overflow !== 1'b0 || pix_mean !== 8'd255)
            $display("FAIL wide_counts: cnt %0d ovf %b mean %0d want 20 0 255", pix_count, overflow, pix_mean); else passes++;
        tick();
        checks++; if (frame_dropped !== 1'b0) $display("FAIL sat_drop_clear: got %b want 0", frame_dropped); else passes++;
    endtask

    task automatic test_reset_mid();
        int seen;
        frame_start = 1'b1; threshold = 8'd0; tick();
        frame_start = 1'b0; pixel_in = 8'd77; pixel_valid = 1'b1; tick(); tick();
        rst_n = 1'b0;
        #2;
        checks++; if (pix_count !== 16'd0 || pix_max !== 8'd0 || pix_mean !== 8'd0)
            $display("FAIL rst_mid_out: cnt %0d max %0d mean %0d want 0 0 0", pix_count, pix_max, pix_mean); else passes++;
        checks++; if (busy !== 1'b0 || s_overflow !== 1'b0) $display("FAIL rst_mid_state: busy %b s_ovf %b want 0 0", busy, s_overflow); else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        pixel_valid = 1'b0; frame_done = 1'b1; tick(); frame_done = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (feat_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_mid_noresult: %0d active cycles want 0", seen); else passes++;
    endtask

`ifdef FEAT_HIST_EN
    task automatic test_hist();
        q = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd255};
        run_frame(8'd0);
        checks++; if (hist0 !== 16'd1 || hist1 !== 16'd1 || hist2 !== 16'd1 || hist3 !== 16'd2)
            $display("FAIL hist_bins: got %0d,%0d,%0d,%0d want 1,1,1,2", hist0, hist1, hist2, hist3); else passes++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_uniform();
        test_ramp();
        test_empty();
        test_backpressure();
        test_same_cycle();
        test_saturate();
        test_reset_mid();
`ifdef FEAT_HIST_EN
        test_hist();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
